// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, frame geometry and divider defaults.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  localparam int unsigned FrameBits     = 10;
  localparam int unsigned DataBits      = 8;
  localparam int unsigned DivWidth      = 16;
  localparam int unsigned DivMinDefault = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; full/empty are derived from the level, pointers wrap.
module sync_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic [$clog2(Depth):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned LvlW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_d;
    end
  end

  // Storage is deliberately left out of reset; only the pointers and level define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: 8N1 frames, divider latched at frame start, back-to-back frames.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_MIN    = DivMinDefault
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [DivWidth-1:0]         cfg_div,
  input  logic                        in_valid,
  input  logic [DataBits-1:0]         in_data,
  output logic                        in_ready,
  output logic                        ser_tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned BitW = $clog2(DataBits);
  localparam logic [DivWidth-1:0] DivMin = DivWidth'(DIV_MIN);

  tx_state_e             state_q, state_d;
  logic [DivWidth-1:0]   div_q, div_d, cnt_q, cnt_d, div_eff;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DataBits-1:0]   shift_q, shift_d, fifo_rdata;
  logic                  tx_q, tx_d;
  logic                  fifo_pop, fifo_full, fifo_empty, bit_end, launch;

  sync_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (DataBits)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .push_i  (in_valid),
    .wdata_i (in_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state_q != StIdle) || !fifo_empty;
  assign ser_tx   = tx_q;
  assign div_eff  = (cfg_div < DivMin) ? DivMin : cfg_div;
  assign bit_end  = (cnt_q == div_q - DivWidth'(1));

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    launch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        launch = !fifo_empty;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end else begin
          cnt_d = cnt_q + DivWidth'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == BitW'(DataBits - 1)) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + BitW'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + DivWidth'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d  = '0;
          launch = !fifo_empty;
          if (fifo_empty) state_d = StIdle;
        end else begin
          cnt_d = cnt_q + DivWidth'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // Frame launch is shared by IDLE and end-of-STOP so consecutive frames have no gap.
    if (launch) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_rdata;
      tx_d     = 1'b0;
      div_d    = div_eff;
      cnt_d    = '0;
      state_d  = StStart;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: accepted bytes are queued, a serial monitor decodes ser_tx and compares.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [15:0] cfg_div;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready, ser_tx, busy;
  logic [3:0]  fifo_level;

  int checks, errors, cyc;
  logic [7:0] sb[$];
  int starts[$];

  int m_div, m_errs;
  bit m_abort;
  logic [FrameBits-1:0] m_bits;

  uart_tx_fifo #(
    .FIFO_DEPTH (8),
    .DIV_MIN    (2)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cfg_div    (cfg_div),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ser_tx     (ser_tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b, output bit acc);
    in_valid = 1'b1;
    in_data  = b;
    acc      = in_ready;
    @(posedge clk);
    #1;
    if (acc) sb.push_back(b);
  endtask

  task automatic busy_len(input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
      else break;
    end
  endtask

  // Serial monitor: each bit must be stable for the divider latched at the start bit.
  always begin
    @(negedge clk);
    if (resetn === 1'b1 && ser_tx === 1'b0) begin
      starts.push_back(cyc);
      m_div   = (cfg_div < 16'd2) ? 2 : int'(cfg_div);
      m_errs  = 0;
      m_abort = 1'b0;
      for (int k = 0; k < int'(FrameBits) * m_div; k++) begin
        if (k > 0) @(negedge clk);
        if (resetn !== 1'b1) begin
          m_abort = 1'b1;
          break;
        end
        if (k % m_div == 0) m_bits[k / m_div] = ser_tx;
        else if (ser_tx !== m_bits[k / m_div]) m_errs++;
      end
      if (!m_abort) begin
        if (m_bits[0] !== 1'b0) m_errs++;
        if (m_bits[FrameBits-1] !== 1'b1) m_errs++;
        check_eq("frame_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) check_eq("rx_byte", 32'(m_bits[8:1]), 32'(sb.pop_front()));
        check_eq("frame_shape", m_errs, 0);
      end
    end
  end

  initial begin
    bit acc;
    int n, p, s0, n_acc, first_low, lows;
    cfg_div  = 16'd50;
    in_valid = 1'b0;
    in_data  = 8'h00;

    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ser_tx", ser_tx, 1);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_level", fifo_level, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Basic 0x41 frame at 50 clk/bit.
    push(8'h41, acc);
    p = cyc;
    in_valid = 1'b0;
    check_eq("accept_41", acc, 1);
    busy_len(1000, n);
    check_eq("frame_busy_len", n, 501);
    check_eq("start_latency", starts.size() > 0 ? starts[starts.size()-1] - p : -1, 1);
    check_eq("sb_empty_basic", sb.size(), 0);

    // Fill: 12 offered bytes, 9 accepted.
    n_acc = 0;
    first_low = -1;
    for (int i = 0; i < 12; i++) begin
      if (!in_ready && first_low < 0) first_low = i;
      push(8'(i), acc);
      if (acc) n_acc++;
    end
    in_valid = 1'b0;
    check_eq("fill_accepted", n_acc, 9);
    check_eq("fill_ready_low_idx", first_low, 9);
    check_eq("fill_level", fifo_level, 8);
    check_eq("fill_in_ready", in_ready, 0);
    busy_len(6000, n);
    check_eq("fill_busy_len", n, 4490);
    check_eq("sb_empty_fill", sb.size(), 0);

    // Back-to-back "Hi\n".
    s0 = starts.size();
    push(8'h48, acc);
    push(8'h69, acc);
    push(8'h0A, acc);
    in_valid = 1'b0;
    busy_len(3000, n);
    check_eq("b2b_busy_len", n, 1499);
    check_eq("b2b_frames", starts.size() - s0, 3);
    check_eq("b2b_gap1", starts[s0+1] - starts[s0], 500);
    check_eq("b2b_gap2", starts[s0+2] - starts[s0+1], 500);
    check_eq("sb_empty_b2b", sb.size(), 0);

    // Divider clamp: cfg_div=0 behaves as 2.
    cfg_div = 16'd0;
    push(8'h55, acc);
    in_valid = 1'b0;
    busy_len(200, n);
    check_eq("clamp_busy_len", n, 21);
    check_eq("sb_empty_clamp", sb.size(), 0);

    // Divider change mid-frame only affects the next frame.
    cfg_div = 16'd50;
    s0 = starts.size();
    push(8'hA5, acc);
    push(8'h3C, acc);
    in_valid = 1'b0;
    repeat (200) @(negedge clk);
    cfg_div = 16'd25;
    busy_len(2000, n);
    check_eq("div_change_busy_len", n + 200, 750);
    check_eq("div_change_gap", starts[s0+1] - starts[s0], 500);
    check_eq("sb_empty_div", sb.size(), 0);

    // Reset at clock 230 of a 0x41 frame with 3 bytes queued.
    cfg_div = 16'd50;
    s0 = starts.size();
    push(8'h41, acc);
    push(8'h11, acc);
    push(8'h22, acc);
    push(8'h33, acc);
    in_valid = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (starts.size() > s0 && cyc - starts[s0] >= 230) break;
    end
    check_eq("pre_rst_ser_tx", ser_tx, 0);
    check_eq("pre_rst_level", fifo_level, 3);
    resetn = 1'b0;
    #1;
    check_eq("midrst_ser_tx", ser_tx, 1);
    check_eq("midrst_level", fifo_level, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    sb.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    lows = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (ser_tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check_eq("post_rst_quiet", lows, 0);
    check_eq("post_rst_frames", starts.size() - s0, 1);

    cfg_div = 16'd4;
    push(8'h5A, acc);
    in_valid = 1'b0;
    busy_len(200, n);
    check_eq("post_rst_busy_len", n, 41);
    check_eq("sb_empty_post_rst", sb.size(), 0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
